// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - nibble-serial W-bit sequencer around a single 4-bit ALU

module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] aluop,
  input  logic       l,
  input  logic       c_in,
  output logic [3:0] r,
  output logic       c_out,
  output logic       zero,
  output logic       sign
);
  logic [4:0] sum;
  logic [3:0] lres;

  // Arithmetic: 00 a+cin, 01 a+~b+cin, 10 a+b+cin, 11 a-1+cin; logic: and/or/xor/not-a
  always_comb begin
    sum = 5'd0;
    unique case (aluop)
      2'b00: sum = {1'b0, a} + {4'b0000, c_in};
      2'b01: sum = {1'b0, a} + {1'b0, ~b} + {4'b0000, c_in};
      2'b10: sum = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
      2'b11: sum = {1'b0, a} + 5'h0F + {4'b0000, c_in};
      default: sum = 5'd0;
    endcase
  end

  always_comb begin
    lres = 4'd0;
    unique case (aluop)
      2'b00: lres = a & b;
      2'b01: lres = a | b;
      2'b10: lres = a ^ b;
      2'b11: lres = ~a;
      default: lres = 4'd0;
    endcase
  end

  assign r     = l ? lres : sum[3:0];
  assign c_out = l ? 1'b0 : sum[4];
  assign zero  = (r == 4'd0);
  assign sign  = r[3];
endmodule

module alu_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [1:0]           aluop,
  input  logic                 l,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 c_out,
  output logic                 zero,
  output logic                 sign
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
  logic [1:0]       aluop_q, aluop_d;
  logic             l_q, l_d, cin_q, cin_d, carry_q, carry_d, acc_zero_q, acc_zero_d;
  logic             c_out_q, c_out_d, zero_q, zero_d, sign_q, sign_d;

  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_cin, alu_c, alu_z, alu_sign_unused;

  assign alu_a   = a_q[{idx_q, 2'b00} +: 4];
  assign alu_b   = b_q[{idx_q, 2'b00} +: 4];
  // Logic mode has no carry chain: every nibble sees the latched cin.
  assign alu_cin = ((idx_q == '0) || l_q) ? cin_q : carry_q;

  alu u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .aluop (aluop_q),
    .l     (l_q),
    .c_in  (alu_cin),
    .r     (alu_r),
    .c_out (alu_c),
    .zero  (alu_z),
    .sign  (alu_sign_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    aluop_d    = aluop_q;
    l_d        = l_q;
    cin_d      = cin_q;
    carry_d    = carry_q;
    acc_zero_d = acc_zero_q;
    work_d     = work_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    if (state_q == IDLE && start) begin
      a_d        = op_a;
      b_d        = op_b;
      aluop_d    = aluop;
      l_d        = l;
      cin_d      = cin;
      idx_d      = '0;
      acc_zero_d = 1'b1;
      carry_d    = 1'b0;
      work_d     = '0;
    end else if (state_q == RUN) begin
      work_d[{idx_q, 2'b00} +: 4] = alu_r;
      carry_d    = alu_c;
      acc_zero_d = acc_zero_q & alu_z;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        result_d = work_d;
        c_out_d  = l_q ? 1'b0 : alu_c;
        zero_d   = acc_zero_q & alu_z;
        sign_d   = l_q ? 1'b0 : work_d[W-1];
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluop_q    <= '0;
      l_q        <= 1'b0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      acc_zero_q <= 1'b0;
      work_q     <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      aluop_q    <= aluop_d;
      l_q        <= l_d;
      cin_q      <= cin_d;
      carry_q    <= carry_d;
      acc_zero_q <= acc_zero_d;
      work_q     <= work_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that runs W-bit operations (W = 4·NIBBLES) through a single 4-bit `alu` instance, one nibble per clock, least-significant nibble first. In arithmetic mode it chains the carry between nibbles. It accumulates the zero flag across nibbles and presents registered result and flags with a start/busy/done handshake. It sits between the operand source and the 4-bit ALU datapath, so wider operands reuse the existing ALU without replicating it.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation (≥2); W = 4·NIBBLES
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- op_a  in  W  operand A, sampled on accepted start
- op_b  in  W  operand B, sampled on accepted start
- aluop  in  2  ALU operation code, sampled on accepted start, applied unchanged to every nibble
- l  in  1  0 = arithmetic unit, 1 = logic unit; sampled on accepted start
- cin  in  1  carry into nibble 0, sampled on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  W  registered result
- c_out  out  1  carry out of top nibble (l=0); 0 when l=1
- zero  out  1  1 iff result == 0
- sign  out  1  result[W-1] when l=0; 0 when l=1 (never X)

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1: latch op_a, op_b, aluop, l, cin; idx=0; acc_zero=1.
  - RUN: stay while idx < NIBBLES-1, then →DONE.
  - DONE→IDLE unconditionally.
- RUN, per cycle:
  - ALU A = op_a[4·idx+3:4·idx]; ALU B = op_b nibble idx; ALUOP = latched aluop; l = latched l.
  - ALU c_in: latched cin for idx=0. For idx>0, the registered c_out of nibble idx-1 when l=0, latched cin when l=1.
  - On the edge: write the ALU R into the working-result nibble idx; store the ALU c_out in the carry register; acc_zero &= ALU zero; idx++.
- On the RUN→DONE edge, load the output registers from the working result and accumulators:
  - result = working result.
  - c_out = last carry when l=0, else 0.
  - zero = acc_zero including the last nibble.
  - sign = top result bit when l=0, else 0.
- Outputs result, c_out, zero, sign hold until the next DONE load. A new start does not clear them.
- The ALU's own sign output is unused; sign is derived from result.
- idx width is ceil(log2(NIBBLES)); idx never wraps inside an operation.

## Timing
- Reset (async assert, sync-style release on next edge): state=IDLE, idx=0, busy=0, done=0, result=0, c_out=0, zero=0, sign=0, internal registers 0.
- Latency: start accepted at edge k. RUN occupies cycles k+1 … k+NIBBLES. done=1 and new outputs valid in cycle k+NIBBLES+1. IDLE from k+NIBBLES+2.
- Throughput: one operation per NIBBLES+2 cycles. The earliest next accepted start is the edge ending the first IDLE cycle.
- start while busy (RUN or DONE): ignored, no effect on latched operands or outputs. start may be held high; it is re-accepted once IDLE is reached.
- done is high for exactly one cycle per accepted start and never high in IDLE.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values, no done pulse. The first start after release is processed normally.
- Operand inputs may change freely after the accepting edge.

## Test plan
- NIBBLES=4, add: start with op_a=0x00FF, op_b=0x0001, aluop=2'b10, l=0, cin=0 → done exactly 5 cycles after the accepting edge; result=0x0100, c_out=0, zero=0, sign=0. Checks carry propagation across nibbles 0→1→2.
- Wrap-around: op_a=0xFFFF, op_b=0x0001, aluop=2'b10, l=0, cin=0 → result=0x0000, c_out=1, zero=1, sign=0. Repeat with op_b=0x0000, cin=1 → same result.
- Sign boundary: op_a=0x7FFF, op_b=0x0001, aluop=2'b10, l=0 → result=0x8000, sign=1, c_out=0, zero=0.
- Logic mode, all four aluop codes, l=1, op_a=0xA5C3, op_b=0x3C96 → result equals per-nibble 4-bit ALU model output concatenated; c_out=0, sign=0; zero matches result==0.
- Handshake: hold start=1 for 12 cycles with changing operands → exactly two done pulses, each matching operands present at its accepting edge; start pulses during busy cause no extra done.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle → busy, done, result, c_out, zero, sign all 0 immediately. Release, then start 0x1234+0x1111 (aluop=2'b10, l=0, cin=0) → result=0x2345.
